// File: rtl/mac_accumulator_6bit_pkg.sv
// Shared widths, FSM encoding and sum-width derivation for the 6-bit MAC accumulator.
package mac_accumulator_6bit_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned PROD_W = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Product width plus one bit per doubling of LEN keeps the sum overflow-free.
  function automatic int unsigned acc_width(input int unsigned len);
    return PROD_W + $clog2(len);
  endfunction

endpackage

// File: rtl/multiplier_6bit.sv
// Combinational 6x6 unsigned multiplier producing a 13-bit product.
module multiplier_6bit
  import mac_accumulator_6bit_pkg::*;
(
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic [PROD_W-1:0] ans
);

  assign ans = PROD_W'(A) * PROD_W'(B);

endmodule

// File: rtl/mac_accumulator_6bit.sv
// Accumulates LEN operand-pair products and hands the sum out over valid/ready.
module mac_accumulator_6bit
  import mac_accumulator_6bit_pkg::*;
#(
  parameter  int unsigned LEN   = 4,
  localparam int unsigned ACC_W = acc_width(LEN),
  localparam int unsigned CNT_W = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  A,
  input  logic [OP_W-1:0]  B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic [CNT_W-1:0] cnt
);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [PROD_W-1:0]  prod;
  logic [ACC_W-1:0]   prod_ext;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               accept;
  logic               last;

  multiplier_6bit u_mul (
    .A   (A),
    .B   (B),
    .ans (prod)
  );

  assign prod_ext = ACC_W'(prod);
  assign cnt_nxt  = cnt + CNT_W'(1);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt_nxt == CNT_W'(LEN));
  assign sum      = acc;

  // rst and clr both drop any partial or pending group; rst simply wins by ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            acc <= (state == IDLE) ? prod_ext : acc + prod_ext;
            cnt <= cnt_nxt;
            if (last) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          acc       <= '0;
          cnt       <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator_6bit.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and random traffic vs a queue model.
module tb_mac_accumulator_6bit;

  localparam int unsigned LEN = 4;

  logic        clk;
  logic        rst, clr;
  logic        in_valid, in_ready;
  logic [5:0]  a, b;
  logic        out_valid, out_ready;
  logic [14:0] sum;
  logic [2:0]  cnt;

  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [5:0]  a1, b1;
  logic [12:0] sum1;
  logic [0:0]  cnt1;

  int checks   = 0;
  int failures = 0;
  int grp[$];

  mac_accumulator_6bit #(.LEN(LEN)) u_dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cnt(cnt)
  );

  mac_accumulator_6bit #(.LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(1'b0),
    .in_valid(in_valid1), .in_ready(in_ready1), .A(a1), .B(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][5:0] a;      // a[3] applied first
    logic [3:0][5:0] b;
    logic [14:0]     exp_sum;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the current group is just the list of accepted products; a full list is the pending result.
  task automatic tick();
    if (rst || clr) grp.delete();
    else if (grp.size() == LEN) begin
      if (out_ready) grp.delete();
    end else if (in_valid) grp.push_back(int'(a) * int'(b));
    @(posedge clk); #1;
    chk("out_valid", out_valid, grp.size() == LEN);
    chk("in_ready", in_ready, grp.size() != LEN);
    chk("cnt", cnt, grp.size());
    if (grp.size() == LEN) chk("sum_model", sum, grp.sum());
  endtask

  task automatic apply(input int pa, input int pb);
    in_valid = 1'b1; a = 6'(pa); b = 6'(pb);
    tick();
    in_valid = 1'b0;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{a: {6'd0, 6'd27, 6'd63, 6'd63}, b: {6'd0, 6'd2, 6'd63, 6'd42}, exp_sum: 15'd6669};
    vecs[1] = '{a: {6'd63, 6'd63, 6'd63, 6'd63}, b: {6'd63, 6'd63, 6'd63, 6'd63}, exp_sum: 15'd15876};
    vecs[2] = '{a: {6'd1, 6'd1, 6'd1, 6'd1}, b: {6'd1, 6'd1, 6'd1, 6'd1}, exp_sum: 15'd4};
    vecs[3] = '{a: {6'd1, 6'd3, 6'd5, 6'd7}, b: {6'd2, 6'd4, 6'd6, 6'd8}, exp_sum: 15'd100};

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_sum", sum, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);

    // Back-to-back groups from the table, consumer always ready.
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b1; a = vecs[v].a[3-i]; b = vecs[v].b[3-i];
        tick();
      end
      in_valid = 1'b0;
      chk("vec_out_valid", out_valid, 1);
      chk("vec_sum", sum, vecs[v].exp_sum);
      chk("vec_cnt", cnt, 4);
      if (v == 1) chk("no_wrap_bit14", sum[14], 0);
      tick();
      chk("vec_back_idle", out_valid, 0);
    end

    // Backpressure: sum held, extra pairs ignored, next group restarts.
    out_ready = 1'b0;
    apply(0, 0); apply(27, 2); apply(63, 63); apply(63, 42);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 6'd9; b = 6'd9;
      tick();
      chk("bp_sum_hold", sum, 6669);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_released", out_valid, 0);
    chk("bp_cnt_zero", cnt, 0);

    // Bubbles between accepts.
    begin
      int vpat[7] = '{1, 0, 0, 1, 1, 0, 1};
      int pa[4] = '{1, 2, 4, 6};
      int pb[4] = '{1, 3, 5, 7};
      int k = 0;
      for (int i = 0; i < 7; i++) begin
        in_valid = vpat[i][0];
        a = 6'(pa[k]); b = 6'(pb[k]);
        tick();
        if (vpat[i] != 0) k++;
      end
      in_valid = 1'b0;
      chk("bubble_sum", sum, 69);
      chk("bubble_valid", out_valid, 1);
      tick();
    end

    // clr mid-group discards the partial sum.
    apply(27, 2); apply(27, 2);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_cnt", cnt, 0);
    chk("clr_out_valid", out_valid, 0);
    apply(1, 1); apply(1, 1); apply(1, 1); apply(1, 1);
    chk("after_clr_sum", sum, 4);
    tick();

    // rst while a result is pending.
    out_ready = 1'b0;
    apply(63, 63); apply(1, 1); apply(2, 2); apply(3, 3);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_done_valid", out_valid, 0);
    chk("rst_done_sum", sum, 0);
    chk("rst_done_in_ready", in_ready, 1);

    // LEN=1 build: one accept completes the group.
    in_valid1 = 1'b1; a1 = 6'd63; b1 = 6'd42;
    tick();
    in_valid1 = 1'b0;
    chk("len1_valid", out_valid1, 1);
    chk("len1_sum", sum1, 2646);
    chk("len1_in_ready", in_ready1, 0);
    out_ready1 = 1'b1;
    tick();
    chk("len1_released", out_valid1, 0);

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      clr       = ($urandom_range(0, 40) == 0);
      a = 6'($urandom_range(0, 63));
      b = 6'($urandom_range(0, 63));
      tick();
    end
    clr = 1'b0; in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
